// File: rtl/aes_round_sequencer.sv
// Iterative AES-encrypt controller: initial AddRoundKey, then nr passes through an
// external combinational round datapath, one per clock, with valid/ready handshakes.

module aes_key_lane #(
  parameter int nr = 10
) (
  input  logic [32*(nr+1)-1:0] keys,
  input  logic [3:0]           sel,
  output logic [31:0]          word
);
  always_comb begin
    word = keys[31:0];
    for (int r = 1; r <= nr; r++)
      if (sel == 4'(r)) word = keys[32*r +: 32];
  end
endmodule

module aes_round_sequencer #(
  parameter int nk = 4,
  parameter int nr = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [0:127]            in_block,
  input  logic [0:128*(nr+1)-1]   key_e,
  output logic [0:127]            rnd_in,
  output logic [0:127]            rnd_key,
  output logic                    rnd_last,
  input  logic [0:127]            rnd_out,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [0:127]            out_block,
  output logic                    busy,
  output logic [3:0]              round_idx
);
  localparam int          NUM_LANES = 4;
  localparam int          VEC_W     = 32;
  localparam logic [3:0]  LAST      = 4'(nr);

  if (nr != nk + 6 || nr > 15) begin : g_bad_cfg
    $error("aes_round_sequencer: nr must equal nk+6");
  end

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t                               state, state_nxt;
  logic [0:127]                         state_reg;
  logic [3:0]                           round;
  logic                                 armed;
  logic                                 accept;
  logic [3:0]                           key_sel;
  logic [NUM_LANES-1:0][32*(nr+1)-1:0]  lane_keys;
  logic [NUM_LANES-1:0][VEC_W-1:0]      key_words;

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)         state_nxt = RUN;
      RUN:     if (round == LAST)  state_nxt = DONE;
      DONE:    if (out_ready)      state_nxt = IDLE;
      default:                     state_nxt = IDLE;
    endcase
  end

  // armed holds in_ready low until the first edge after reset release
  always_comb begin
    in_ready  = armed && (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
    rnd_last  = (state == RUN) && (round == LAST);
    out_block = (state == DONE) ? state_reg : '0;
    rnd_in    = state_reg;
    key_sel   = (state == RUN) ? round : 4'd0;
    round_idx = round;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed     <= 1'b0;
      state_reg <= '0;
      round     <= '0;
    end else begin
      armed <= 1'b1;
      case (state)
        IDLE: if (accept) begin
          state_reg <= in_block ^ key_e[0:127];
          round     <= 4'd1;
        end
        RUN: begin
          state_reg <= rnd_out;
          if (round != LAST) round <= round + 4'd1;
        end
        DONE: if (out_ready) round <= '0;
        default: ;
      endcase
    end
  end

  // Each lane owns one 32-bit column of every round key and muxes it by round.
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    for (genvar r = 0; r <= nr; r++) begin : g_rnd
      assign lane_keys[g][VEC_W*r +: VEC_W] = key_e[128*r + VEC_W*g +: VEC_W];
    end
    aes_key_lane #(.nr(nr)) u_lane (
      .keys (lane_keys[g]),
      .sel  (key_sel),
      .word (key_words[g])
    );
    assign rnd_key[VEC_W*g +: VEC_W] = key_words[g];
  end
endmodule
